// File: rtl/lutnet_pkg.sv
// Shared definitions for the programmable LUT neuron: FSM state encoding and
// default geometry (lookup address width, entry width).
// Ports: none (package).
package lutnet_pkg;

   localparam int LUTNET_IN_BITS  = 8;
   localparam int LUTNET_OUT_BITS = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } lut_state_e;

endpackage

// File: rtl/lutnet_neuron_prog_if.sv
// Configuration stream, lookup request and lookup result bundle for the
// programmable LUT neuron. slave = neuron side, master = driver side.
// Signals: cfg_start/cfg_valid/cfg_data/cfg_ready/loaded, in_valid/in_data/in_ready,
//          out_valid/out_data/out_ready.
interface lutnet_neuron_prog_if #(
   parameter int IN_BITS  = lutnet_pkg::LUTNET_IN_BITS,
   parameter int OUT_BITS = lutnet_pkg::LUTNET_OUT_BITS
);
   logic                cfg_start;
   logic                cfg_valid;
   logic [OUT_BITS-1:0] cfg_data;
   logic                cfg_ready;
   logic                loaded;
   logic                in_valid;
   logic [IN_BITS-1:0]  in_data;
   logic                in_ready;
   logic                out_valid;
   logic [OUT_BITS-1:0] out_data;
   logic                out_ready;

   modport master (
      output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
      input  cfg_ready, loaded, in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
      output cfg_ready, loaded, in_ready, out_valid, out_data
   );
endinterface

// File: rtl/lutnet_dpram.sv
// 2**AW x DW distributed RAM: one synchronous write port, NRD asynchronous read ports.
// Ports: clk, we/wr_addr/wr_data (write), rd_addr[NRD]/rd_data[NRD] (combinational reads).
// Contents are never reset; the owner must load the table before trusting reads.
module lutnet_dpram #(
   parameter int AW  = 8,
   parameter int DW  = 2,
   parameter int NRD = 1
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [AW-1:0]           wr_addr,
   input  logic [DW-1:0]           wr_data,
   input  logic [NRD-1:0][AW-1:0]  rd_addr,
   output logic [NRD-1:0][DW-1:0]  rd_data
);

   (* ram_style = "distributed", rom_style = "distributed" *)
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign rd_data[i] = mem[rd_addr[i]];
   end

endmodule

// File: rtl/lutnet_neuron_prog.sv
// Run-time-programmable LUT neuron: a truth table is streamed into distributed RAM
// (IDLE -> LOAD -> RUN), then IN_BITS-address lookups are served with a registered
// result one cycle after acceptance, 1 lookup/cycle.
// Ports: clk, rst (sync, active-high), bus (lutnet_neuron_prog_if.slave);
// with LUTNET_READBACK_EN defined also rb_en/rb_addr/rb_data (registered debug readback).
module lutnet_neuron_prog
   import lutnet_pkg::*;
#(
   parameter int IN_BITS  = LUTNET_IN_BITS,
   parameter int OUT_BITS = LUTNET_OUT_BITS
) (
   input  logic                clk,
   input  logic                rst,
   lutnet_neuron_prog_if.slave bus
`ifdef LUTNET_READBACK_EN
   ,
   input  logic                rb_en,
   input  logic [IN_BITS-1:0]  rb_addr,
   output logic [OUT_BITS-1:0] rb_data
`endif
);

`ifdef LUTNET_READBACK_EN
   localparam int NRD = 2;
`else
   localparam int NRD = 1;
`endif

   lut_state_e          state_q, state_d;
   logic [IN_BITS-1:0]  addr_q, addr_d;
   logic                out_valid_q, out_valid_d;
   logic [OUT_BITS-1:0] out_data_q, out_data_d;

   logic                in_ready;
   logic                lookup_acc;
   logic                cfg_wr;
   logic [NRD-1:0][IN_BITS-1:0]  rd_addr;
   logic [NRD-1:0][OUT_BITS-1:0] rd_data;

   // A new result may be loaded when the output register is empty or draining this cycle.
   assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
   assign lookup_acc = bus.in_valid && in_ready;
   // cfg_start wins over a coincident word: the restart drops it and rewinds to entry 0.
   assign cfg_wr     = (state_q == ST_LOAD) && bus.cfg_valid && !bus.cfg_start;

   assign bus.cfg_ready = (state_q == ST_LOAD);
   assign bus.loaded    = (state_q == ST_RUN);
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   assign rd_addr[0] = bus.in_data;

   lutnet_dpram #(
      .AW  (IN_BITS),
      .DW  (OUT_BITS),
      .NRD (NRD)
   ) u_ram (
      .clk     (clk),
      .we      (cfg_wr),
      .wr_addr (addr_q),
      .wr_data (bus.cfg_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Next state / load address.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cfg_start) begin
               state_d = ST_LOAD;
               addr_d  = '0;
            end
         end
         ST_LOAD: begin
            if (bus.cfg_start) begin
               addr_d = '0;
            end else if (bus.cfg_valid) begin
               // Last entry finishes the load; the counter is held, never wrapped.
               if (addr_q == '1) begin
                  state_d = ST_RUN;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (bus.cfg_start) begin
               state_d = ST_LOAD;
               addr_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
      endcase
   end

   // Output register: a lookup accepted alongside cfg_start still reads the old
   // table (no write happens that cycle), and a held result survives a reload.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (lookup_acc) begin
         out_valid_d = 1'b1;
         out_data_d  = rd_data[0];
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef LUTNET_READBACK_EN
   logic [OUT_BITS-1:0] rb_data_q, rb_data_d;

   assign rd_addr[1] = rb_addr;
   assign rb_data    = rb_data_q;

   always_comb begin
      rb_data_d = rb_data_q;
      if (rb_en) begin
         rb_data_d = rd_data[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rb_data_q <= '0;
      end else begin
         rb_data_q <= rb_data_d;
      end
   end
`endif

endmodule

// File: tb/tb_lutnet_neuron_prog.sv
module tb_lutnet_neuron_prog;
   import lutnet_pkg::*;

   localparam int IB    = LUTNET_IN_BITS;
   localparam int OB    = LUTNET_OUT_BITS;
   localparam int DEPTH = 1 << IB;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lutnet_neuron_prog_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus ();

`ifdef LUTNET_READBACK_EN
   logic          rb_en;
   logic [IB-1:0] rb_addr;
   logic [OB-1:0] rb_data;

   lutnet_neuron_prog #(.IN_BITS(IB), .OUT_BITS(OB)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .rb_en   (rb_en),
      .rb_addr (rb_addr),
      .rb_data (rb_data)
   );
`else
   lutnet_neuron_prog #(.IN_BITS(IB), .OUT_BITS(OB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   int checks = 0;
   int passed = 0;
   int results_seen = 0;
   logic [OB-1:0] model [DEPTH];
   logic [OB-1:0] sb_q [$];

   function automatic logic [OB-1:0] tbl(input int mode, input int a);
      logic [7:0] av;
      av = a[7:0];
      case (mode)
         0:       return av[1:0];
         1:       return ~av[1:0];
         default: return av[7:6] + 2'd1;
      endcase
   endfunction

   // Scoreboard: pop on every transferred result, push on every accepted request.
   always @(negedge clk) begin
      logic [OB-1:0] exp_v;
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         checks++;
         results_seen++;
         if (sb_q.size() == 0) begin
            $display("FAIL sb_unexpected: out_data=%0h, required no result", bus.out_data);
         end else begin
            exp_v = sb_q.pop_front();
            if (bus.out_data !== exp_v)
               $display("FAIL sb_data: out_data=%0h, required %0h", bus.out_data, exp_v);
            else
               passed++;
         end
      end
      if (rst === 1'b0 && bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
         sb_q.push_back(model[bus.in_data]);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (sb_q.size() != 0)
         $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
      else
         passed++;
   endtask

   task automatic check_idle_outputs(input string name);
      @(negedge clk);
      checks++;
      if ({bus.cfg_ready, bus.loaded, bus.in_ready, bus.out_valid, bus.out_data} !== '0)
         $display("FAIL %s: cfg_ready=%b loaded=%b in_ready=%b out_valid=%b out_data=%0h, required all 0",
                  name, bus.cfg_ready, bus.loaded, bus.in_ready, bus.out_valid, bus.out_data);
      else
         passed++;
   endtask

   // cfg_start pulse then n words; when n == DEPTH also checks loaded timing.
   task automatic load_words(input int mode, input int n, input string name);
      int bad = 0;
      bus.cfg_start = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = tbl(mode, i);
         @(negedge clk);
         if (bus.cfg_ready !== 1'b1 || bus.loaded !== 1'b0) bad++;
         model[i] = tbl(mode, i);
         tick();
      end
      bus.cfg_valid = 1'b0;
      checks++;
      if (bad != 0)
         $display("FAIL %s_load_hs: %0d bad cycles, required 0 (cfg_ready=1, loaded=0)", name, bad);
      else
         passed++;
      if (n == DEPTH) begin
         checks++;
         if (bus.loaded !== 1'b1 || bus.cfg_ready !== 1'b0)
            $display("FAIL %s_loaded: loaded=%b cfg_ready=%b, required 1/0", name, bus.loaded, bus.cfg_ready);
         else
            passed++;
      end
   endtask

   task automatic sweep(input string name);
      int bubbles = 0;
      int base = results_seen;
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = IB'(i);
         @(negedge clk);
         if (bus.in_ready !== 1'b1) bubbles++;
         if (i > 0 && bus.out_valid !== 1'b1) bubbles++;
         tick();
      end
      bus.in_valid = 1'b0;
      drain(name);
      checks++;
      if (bubbles != 0 || results_seen - base != DEPTH)
         $display("FAIL %s_throughput: bubbles=%0d results=%0d, required 0/%0d",
                  name, bubbles, results_seen - base, DEPTH);
      else
         passed++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      check_idle_outputs("reset_state");
      rst = 1'b0;
      tick();
      check_idle_outputs("idle_after_reset");
   endtask

   task automatic test_load_and_lookup();
      load_words(0, DEPTH, "load0");
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hC7;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b11)
         $display("FAIL lookup_c7: out_valid=%b out_data=%0h, required 1/3", bus.out_valid, bus.out_data);
      else
         passed++;
      drain("lookup_c7");
   endtask

   task automatic test_back_to_back();
      sweep("b2b");
   endtask

   task automatic test_backpressure();
      int bad = 0;
      int base = results_seen;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h12;
      tick();
      bus.in_data = 8'h40;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== model[8'h12]) bad++;
         tick();
      end
      checks++;
      if (bad != 0)
         $display("FAIL backpressure_hold: %0d bad cycles, required 0 (out_valid=1 in_ready=0 data stable)", bad);
      else
         passed++;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      drain("backpressure");
      checks++;
      if (results_seen - base != 2)
         $display("FAIL backpressure_count: results=%0d, required 2", results_seen - base);
      else
         passed++;
   endtask

   task automatic test_restart();
      load_words(1, 100, "partial");
      load_words(2, DEPTH, "restart");
      sweep("restart");
   endtask

   task automatic test_cfg_in_run();
      logic [OB-1:0] old_v;
      old_v = model[0];
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h00;
      bus.cfg_start = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL cfg_run_accept: in_ready=%b, required 1", bus.in_ready);
      else
         passed++;
      tick();
      bus.cfg_start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.loaded !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== old_v)
         $display("FAIL cfg_run_old: loaded=%b in_ready=%b out_valid=%b out_data=%0h, required 0/0/1/%0h",
                  bus.loaded, bus.in_ready, bus.out_valid, bus.out_data, old_v);
      else
         passed++;
      tick();
      tick();
      bus.in_valid = 1'b0;
      drain("cfg_run");
      load_words(0, DEPTH, "reload0");
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      tick();
      bus.in_data  = 8'hC7;
      tick();
      bus.in_valid = 1'b0;
      drain("reload0_lookup");
   endtask

   task automatic test_rst_mid();
      int bad = 0;
      load_words(1, 50, "midload");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_outputs("rst_midload");
      bus.in_valid  = 1'b1;
      bus.cfg_valid = 1'b1;
      bus.in_data   = 8'h05;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.cfg_valid = 1'b0;
      checks++;
      if (bad != 0)
         $display("FAIL rst_ignore: %0d bad cycles, required 0", bad);
      else
         passed++;
      load_words(1, DEPTH, "load1");
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h05;
      tick();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb_q.delete();
      check_idle_outputs("rst_midlookup");
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
         $display("FAIL rst_no_lookup: in_ready=%b out_valid=%b, required 0/0", bus.in_ready, bus.out_valid);
      else
         passed++;
      bus.in_valid = 1'b0;
      tick();
   endtask

`ifdef LUTNET_READBACK_EN
   task automatic test_readback();
      load_words(0, DEPTH, "rbload");
      rb_en   = 1'b1;
      rb_addr = 8'h41;
      tick();
      rb_en   = 1'b0;
      rb_addr = 8'h03;
      @(negedge clk);
      checks++;
      if (rb_data !== 2'b01)
         $display("FAIL readback_41: rb_data=%0h, required 1", rb_data);
      else
         passed++;
      tick();
      @(negedge clk);
      checks++;
      if (rb_data !== 2'b01)
         $display("FAIL readback_hold: rb_data=%0h, required 1", rb_data);
      else
         passed++;
   endtask
`endif

   initial begin
      rst           = 1'b1;
      bus.cfg_start = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
`ifdef LUTNET_READBACK_EN
      rb_en   = 1'b0;
      rb_addr = '0;
`endif
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      test_reset();
      test_load_and_lookup();
      test_back_to_back();
      test_backpressure();
      test_restart();
      test_cfg_in_run();
      test_rst_mid();
`ifdef LUTNET_READBACK_EN
      test_readback();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
